// File: rtl/led_7seg_pkg.sv
// -----------------------------------------------------------------------------
// led_7seg_pkg
// Shared types and constants for the multiplexed 7-segment driver.
//   seg_t      : segment vector {g,f,e,d,c,b,a}, always active-high here
//   SEG_DASH   : only segment g lit
//   SEG_BLANK  : every segment off
//   HEX_TABLE  : glyphs for codes 0-F (0-9, A, b, C, d, E, F)
// -----------------------------------------------------------------------------
package led_7seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH  = 7'b1000000;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Index 0 is the first element of the aggregate.
    localparam seg_t HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/led_7seg_scan_if.sv
// -----------------------------------------------------------------------------
// led_7seg_scan_if
// This interface bundles the datapath-side load bus and the board-side pins of the scanner.
//   load       : capture data_in / blank_mask on this clock edge
//   data_in    : nibble i drives digit i (digit 0 is the least significant)
//   blank_mask : 1 forces digit i blank
//   seg        : segment pins {g,f,e,d,c,b,a}, in the polarity chosen by the scanner
//   an         : digit enable pins, in the polarity chosen by the scanner
// The master modport is the datapath side; the slave modport is the scanner.
// -----------------------------------------------------------------------------
interface led_7seg_scan_if
    import led_7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (output load, output data_in, output blank_mask,
                    input  seg,  input  an);

    modport slave  (input  load, input  data_in, input  blank_mask,
                    output seg,  output an);

endinterface

// File: rtl/led_7seg_decode.sv
// -----------------------------------------------------------------------------
// led_7seg_decode
// This module is a combinational nibble-to-glyph decoder. Its output is active-high.
//   nibble   : code to display
//   hex_mode : 1 shows codes 10-15 as A,b,C,d,E,F; 0 shows them as a dash
//   seg      : segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module led_7seg_decode
    import led_7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output seg_t       seg
);

    // The decoder looks up the table first. Outside hex mode, any code above 9 is replaced by a dash.
    always_comb begin
        seg = HEX_TABLE[nibble];
        if (!hex_mode && (nibble > 4'd9)) begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/led_7seg_scan.sv
// -----------------------------------------------------------------------------
// led_7seg_scan
// This is the time-multiplexed driver for NUM_DIGITS 7-segment digits that share one set of segment lines.
// A load captures a packed nibble vector and a blank mask into shadow registers.
// A prescaler then steps a digit index once every SCAN_DIV clocks.
// The seg and an outputs are registered from the index and the shadow registers.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : led_7seg_scan_if.slave (load, data_in, blank_mask in; seg, an out)
// Parameters: NUM_DIGITS (1..8), SCAN_DIV (>=2), HEX_MODE, ACTIVE_LOW.
// Optional feature: define LED_7SEG_LZB_EN to enable leading-zero blanking.
// The blanking is computed from shadow data, and digit 0 is never blanked by it.
// -----------------------------------------------------------------------------
module led_7seg_scan
    import led_7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int HEX_MODE   = 1,
    parameter int ACTIVE_LOW = 1
)(
    input  logic              clk,
    input  logic              rst,
    led_7seg_scan_if.slave    bus
);

    localparam int CNT_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // The reset pin values are a dash on digit 0, already expressed in the output polarity.
    localparam seg_t                  SEG_RST = (ACTIVE_LOW != 0) ? ~SEG_DASH : SEG_DASH;
    localparam logic [NUM_DIGITS-1:0] AN_RST  = (ACTIVE_LOW != 0) ? ~NUM_DIGITS'(1)
                                                                  : NUM_DIGITS'(1);

    logic [CNT_W-1:0]        prescaler_d, prescaler_q;
    logic [IDX_W-1:0]        idx_d, idx_q;
    logic [4*NUM_DIGITS-1:0] data_d, data_q;
    logic [NUM_DIGITS-1:0]   mask_d, mask_q;
    seg_t                    seg_d, seg_q;
    logic [NUM_DIGITS-1:0]   an_d, an_q;

    logic [3:0]              cur_nibble;
    seg_t                    dec_seg;
    seg_t                    seg_raw;
    logic [NUM_DIGITS-1:0]   an_raw;
    logic [NUM_DIGITS-1:0]   lzb_vec;
    logic [NUM_DIGITS-1:0]   blank_vec;

    // This block computes the next state.
    // The prescaler wraps at the end of each slot, and the digit index advances at that same moment.
    // A load updates the shadow registers independently of the slot advance.
    // If both happen on the same edge, the newly selected digit already sees the new data.
    always_comb begin
        prescaler_d = prescaler_q + CNT_W'(1);
        idx_d       = idx_q;
        data_d      = data_q;
        mask_d      = mask_q;
        if (prescaler_q == PRE_LAST) begin
            prescaler_d = '0;
            idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (bus.load) begin
            data_d = bus.data_in;
            mask_d = bus.blank_mask;
        end
    end

`ifdef LED_7SEG_LZB_EN
    logic upper_zero;

    // This block implements leading-zero blanking.
    // It walks down from the most significant digit, and keeps blanking while every nibble seen so far is zero.
    // Digit 0 is excluded so that a value of zero still shows "0".
    always_comb begin
        lzb_vec    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (data_q[4*i +: 4] == 4'd0);
            lzb_vec[i] = upper_zero;
        end
    end
`else
    assign lzb_vec = '0;
`endif

    assign blank_vec  = mask_q | lzb_vec;
    assign cur_nibble = data_q[4*idx_q +: 4];

    led_7seg_decode u_decode (
        .nibble   (cur_nibble),
        .hex_mode (HEX_MODE != 0),
        .seg      (dec_seg)
    );

    // This block builds the pin values for the next cycle.
    // In the first cycle of every slot (prescaler at zero) all enables are dropped.
    // This stops the previous digit's pattern ghosting onto the new digit.
    // The polarity inversion is applied last, so all the logic above it works active-high.
    always_comb begin
        seg_raw = blank_vec[idx_q] ? SEG_BLANK : dec_seg;
        an_raw  = (prescaler_q == '0) ? '0 : (NUM_DIGITS'(1) << idx_q);
        seg_d   = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        an_d    = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
    end

    // This block holds all state registers. A reset mid-scan restarts at digit 0 with a full slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            seg_q       <= SEG_RST;
            an_q        <= AN_RST;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_led_7seg_scan.sv
// -----------------------------------------------------------------------------
// tb_led_7seg_scan
// This is the bench for led_7seg_scan, with NUM_DIGITS=4, SCAN_DIV=4, HEX_MODE=1 and ACTIVE_LOW=1.
// A cycle model predicts the pin values for every clock edge and queues them.
// After each edge the pins are popped and compared against the queued values.
// Directed checks against fixed glyph constants cover reset, scan order, hex glyphs,
// a load at a slot boundary, blanking, and a mid-scan reset.
// -----------------------------------------------------------------------------
module tb_led_7seg_scan;
    import led_7seg_pkg::*;

    localparam int ND = 4;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_7seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    led_7seg_scan #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .HEX_MODE   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
    } pins_t;

    pins_t expQ[$];

    int checks = 0;
    int errors = 0;

    int          mPre  = 0;
    int          mIdx  = 0;
    logic [15:0] mData = '0;
    logic [3:0]  mMask = '0;

    logic [6:0] obsSeg;
    logic [3:0] obsAn;

    logic [6:0] scanSeg [4];

    // This is the glyph table (active-high), taken from standard 7-segment shapes.
    function automatic logic [6:0] refSeg(input logic [3:0] n);
        case (n)
            4'h0: refSeg = 7'b0111111;
            4'h1: refSeg = 7'b0000110;
            4'h2: refSeg = 7'b1011011;
            4'h3: refSeg = 7'b1001111;
            4'h4: refSeg = 7'b1100110;
            4'h5: refSeg = 7'b1101101;
            4'h6: refSeg = 7'b1111101;
            4'h7: refSeg = 7'b0000111;
            4'h8: refSeg = 7'b1111111;
            4'h9: refSeg = 7'b1101111;
            4'hA: refSeg = 7'b1110111;
            4'hB: refSeg = 7'b1111100;
            4'hC: refSeg = 7'b0111001;
            4'hD: refSeg = 7'b1011110;
            4'hE: refSeg = 7'b1111001;
            default: refSeg = 7'b1110001;
        endcase
    endfunction

    // This function decides whether a digit is blanked, from the mask and (when enabled) the leading-zero rule.
    function automatic logic modelBlank(input int idx);
        logic b;
        b = mMask[idx];
`ifdef LED_7SEG_LZB_EN
        if (idx > 0) begin
            logic allZero;
            allZero = 1'b1;
            for (int j = idx; j < ND; j++) begin
                if (mData[4*j +: 4] != 4'd0) allZero = 1'b0;
            end
            b = b | allZero;
        end
`endif
        return b;
    endfunction

    // This task counts one comparison and reports it when the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // This task runs one clock with the inputs as currently driven.
    // It queues the predicted pins, steps the model at the edge, then pops and compares on the falling edge.
    task automatic applyStimulus();
        pins_t e;
        pins_t got;
        logic [6:0] segHi;
        logic [3:0] anHi;
        if (rst) begin
            e.seg = ~7'b1000000;
            e.an  = ~4'b0001;
        end else begin
            segHi = modelBlank(mIdx) ? 7'b0000000 : refSeg(mData[4*mIdx +: 4]);
            anHi  = (mPre == 0) ? 4'b0000 : (4'b0001 << mIdx);
            e.seg = ~segHi;
            e.an  = ~anHi;
        end
        expQ.push_back(e);
        @(posedge clk);
        if (rst) begin
            mPre  = 0;
            mIdx  = 0;
            mData = '0;
            mMask = '0;
        end else begin
            if (mPre == SD - 1) begin
                mPre = 0;
                mIdx = (mIdx + 1) % ND;
            end else begin
                mPre++;
            end
            if (bus.load) begin
                mData = bus.data_in;
                mMask = bus.blank_mask;
            end
        end
        @(negedge clk);
        obsSeg = bus.seg;
        obsAn  = bus.an;
        got    = expQ.pop_front();
        checkOutput("sb_seg", {25'd0, obsSeg}, {25'd0, got.seg});
        checkOutput("sb_an",  {28'd0, obsAn},  {28'd0, got.an});
    endtask

    // This task runs clocks until the model reaches the requested slot position, giving up after a bounded number of clocks.
    task automatic waitSlot(input int idx, input int pre, input string tag);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (mIdx == idx && mPre == pre) begin
                found = 1'b1;
                break;
            end
            applyStimulus();
        end
        checkOutput(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        logic [3:0] expAn;
        logic [6:0] expSeg;

        scanSeg[0] = ~7'b0111111;
        scanSeg[1] = ~7'b0000110;
        scanSeg[2] = ~7'b1011011;
        scanSeg[3] = ~7'b1001111;

        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.data_in    = '0;
        bus.blank_mask = '0;

        $display("[TB] reset held for three cycles");
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("rst_seg", {25'd0, obsSeg}, {25'd0, 7'b0111111});
            checkOutput("rst_an",  {28'd0, obsAn},  {28'd0, 4'b1110});
        end

        $display("[TB] scan order with 3210");
        rst            = 1'b0;
        bus.data_in    = 16'h3210;
        for (int k = 0; k < 18; k++) begin
            bus.load = (k == 0);
            applyStimulus();
            expAn = (k % 4 == 0) ? 4'b1111 : ~(4'b0001 << ((k / 4) % 4));
            checkOutput("scan_an",  {28'd0, obsAn},  {28'd0, expAn});
            checkOutput("scan_seg", {25'd0, obsSeg}, {25'd0, scanSeg[(k / 4) % 4]});
        end

        $display("[TB] hex glyphs with FEDA");
        bus.data_in = 16'hFEDA;
        bus.load    = 1'b1;
        applyStimulus();
        bus.load    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus();
            if (obsAn == 4'b1110) checkOutput("hex_A", {25'd0, obsSeg}, {25'd0, ~7'b1110111});
            if (obsAn == 4'b0111) checkOutput("hex_F", {25'd0, obsSeg}, {25'd0, ~7'b1110001});
        end

        $display("[TB] load coincident with wrap to digit 0");
        waitSlot(3, 3, "bnd_wait");
        bus.data_in = 16'h0005;
        bus.load    = 1'b1;
        applyStimulus();
        bus.load    = 1'b0;
        applyStimulus();
        checkOutput("bnd_ghost_an", {28'd0, obsAn},  {28'd0, 4'b1111});
        applyStimulus();
        checkOutput("bnd_an",       {28'd0, obsAn},  {28'd0, 4'b1110});
        checkOutput("bnd_seg",      {25'd0, obsSeg}, {25'd0, ~7'b1101101});

        $display("[TB] blank mask with 0070");
        bus.data_in    = 16'h0070;
        bus.blank_mask = 4'b0100;
        bus.load       = 1'b1;
        applyStimulus();
        bus.load       = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus();
            case (obsAn)
                4'b1011: checkOutput("blk_d2", {25'd0, obsSeg}, {25'd0, 7'b1111111});
                4'b1101: checkOutput("blk_d1", {25'd0, obsSeg}, {25'd0, ~7'b0000111});
                4'b1110: checkOutput("blk_d0", {25'd0, obsSeg}, {25'd0, ~7'b0111111});
                4'b0111: begin
`ifdef LED_7SEG_LZB_EN
                    expSeg = 7'b1111111;
`else
                    expSeg = ~7'b0111111;
`endif
                    checkOutput("blk_d3", {25'd0, obsSeg}, {25'd0, expSeg});
                end
                default: ;
            endcase
        end

        $display("[TB] all-zero data");
        bus.data_in    = 16'h0000;
        bus.blank_mask = 4'b0000;
        bus.load       = 1'b1;
        applyStimulus();
        bus.load       = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus();
            if (obsAn != 4'b1111) begin
`ifdef LED_7SEG_LZB_EN
                expSeg = (obsAn == 4'b1110) ? ~7'b0111111 : 7'b1111111;
`else
                expSeg = ~7'b0111111;
`endif
                checkOutput("zero_seg", {25'd0, obsSeg}, {25'd0, expSeg});
            end
        end

        $display("[TB] reset during digit 2 slot");
        bus.data_in = 16'h3210;
        bus.load    = 1'b1;
        applyStimulus();
        bus.load    = 1'b0;
        waitSlot(2, 2, "mid_wait");
        rst = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_an",  {28'd0, obsAn},  {28'd0, 4'b1110});
        checkOutput("mid_rst_seg", {25'd0, obsSeg}, {25'd0, 7'b0111111});
        rst = 1'b0;
        applyStimulus();
        checkOutput("mid_first_an", {28'd0, obsAn}, {28'd0, 4'b1111});
        for (int k = 0; k < 16; k++) begin
            applyStimulus();
            if (obsAn != 4'b1111) begin
`ifdef LED_7SEG_LZB_EN
                expSeg = (obsAn == 4'b1110) ? ~7'b0111111 : 7'b1111111;
`else
                expSeg = ~7'b0111111;
`endif
                checkOutput("mid_cleared", {25'd0, obsSeg}, {25'd0, expSeg});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
